counter_seq_ctrl: RTL

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

---
 rtl/counter_seq_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/counter_seq_ctrl.sv
// Start/end/direction run controller: loads a start value, steps modulo 2^WIDTH toward
// a captured terminal value, and supports pause, abort and one-cycle done/wrap pulses.
module counter_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] end_val,
  input  logic             dir,
  input  logic             hold,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] end_q,   end_d;
  logic             dir_q,   dir_d;
  logic             done_q,  done_d;
  logic             wrap_q,  wrap_d;

  // State, counter, captured run parameters and output pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= CNT_ZERO;
      end_q   <= CNT_ZERO;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      end_q   <= end_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state and datapath: abort beats hold, hold beats the terminal check.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    end_d   = end_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d = start_val;
          end_d   = end_val;
          dir_d   = dir;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (hold) begin
          state_d = ST_PAUSE;
        end else if (count_q == end_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (dir_q) begin
          count_d = count_q - CNT_ONE;
          wrap_d  = (count_q == CNT_ZERO);
        end else begin
          count_d = count_q + CNT_ONE;
          wrap_d  = (count_q == CNT_MAX);
        end
      end
      ST_PAUSE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!hold) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE) || (state_q == ST_DONE);
  assign count = count_q;
  assign done  = done_q;
  assign wrap  = wrap_q;

endmodule
